// File: rtl/ps_line_feeder_if.sv
// Pixel/handshake bundle between ps_line_feeder, its upstream FIFO and the kernel controller.
// o_stall_cnt exists only when PS_LINE_FEEDER_STATS_EN is defined.
interface ps_line_feeder_if #(
  parameter int LINE_CNT_W = 9
) ();
  logic                  i_enable;
  logic                  i_fifo_empty;
  logic [7:0]            i_fifo_rdata;
  logic                  o_fifo_rd;
  logic                  i_req;
  logic [7:0]            o_data;
  logic                  o_valid;
  logic [LINE_CNT_W-1:0] o_line_cnt;
  logic                  o_busy;
  logic                  o_frame_done;
`ifdef PS_LINE_FEEDER_STATS_EN
  logic [15:0]           o_stall_cnt;
`endif

  modport master (
    input  i_enable, i_fifo_empty, i_fifo_rdata, i_req,
    output o_fifo_rd, o_data, o_valid, o_line_cnt, o_busy, o_frame_done
`ifdef PS_LINE_FEEDER_STATS_EN
    , output o_stall_cnt
`endif
  );

  modport slave (
    output i_enable, i_fifo_empty, i_fifo_rdata, i_req,
    input  o_fifo_rd, o_data, o_valid, o_line_cnt, o_busy, o_frame_done
`ifdef PS_LINE_FEEDER_STATS_EN
    , input o_stall_cnt
`endif
  );
endinterface

// File: rtl/ps_line_feeder.sv
// Feeds one line of pixels per request from the upstream FIFO, appends a pad line per frame; o_valid 1 cycle after rd, o_data 2.
// FIFO underflow stalls the line indefinitely; PS_LINE_FEEDER_STATS_EN adds a saturating stall counter.
module ps_line_feeder #(
  parameter int         LINE_LENGTH = 640,
  parameter int         FRAME_LINES = 480,
  parameter logic [7:0] PAD_VALUE   = 8'h00
) (
  input logic              i_clk,
  input logic              i_rstn,
  ps_line_feeder_if.master bus
);
  localparam int IC_W = $clog2(LINE_LENGTH + 1);
  localparam int LC_W = $clog2(FRAME_LINES + 1);
  localparam logic [IC_W-1:0] LINE_LAST     = IC_W'(LINE_LENGTH);
  localparam logic [IC_W-1:0] PAD_LAST      = IC_W'(LINE_LENGTH - 1);
  localparam logic [LC_W-1:0] LINE_CNT_LAST = LC_W'(FRAME_LINES);

  typedef enum logic [2:0] {S_IDLE, S_LINE, S_DRAIN, S_PAD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IC_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [LC_W-1:0] line_cnt_q, line_cnt_d;
  logic            rd_q, rd_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            fifo_rd;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    line_cnt_d   = line_cnt_q;
    frame_done_d = 1'b0;
    fifo_rd      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req && bus.i_enable) begin
          state_d     = S_LINE;
          issue_cnt_d = '0;
        end
      end
      S_LINE: begin
        fifo_rd = !bus.i_fifo_empty && (issue_cnt_q < LINE_LAST);
        if (fifo_rd) issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_d == LINE_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        line_cnt_d  = line_cnt_q + 1'b1;
        issue_cnt_d = '0;
        state_d     = (line_cnt_d == LINE_CNT_LAST) ? S_PAD : S_IDLE;
      end
      // issue_cnt doubles as the pad-cycle counter
      S_PAD: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == PAD_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        line_cnt_d   = '0;
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rd_d    = fifo_rd;
    valid_d = fifo_rd || (state_q == S_PAD);
    // FIFO data is captured only for cycles that follow a real read, so pad valids never sample rdata
    if (state_q == S_PAD)  data_d = PAD_VALUE;
    else if (rd_q)         data_d = bus.i_fifo_rdata;
    else                   data_d = data_q;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= '0;
      line_cnt_q   <= '0;
      rd_q         <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      line_cnt_q   <= line_cnt_d;
      rd_q         <= rd_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.o_fifo_rd    = fifo_rd;
  assign bus.o_valid      = valid_q;
  assign bus.o_data       = data_q;
  assign bus.o_line_cnt   = line_cnt_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = frame_done_q;

`ifdef PS_LINE_FEEDER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_DONE)
      stall_cnt_d = '0;
    else if (state_q == S_LINE && issue_cnt_q < LINE_LAST && bus.i_fifo_empty
             && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign bus.o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/ps_line_feeder.md
Name: ps_line_feeder

Overview:
- Sequences pixel delivery from the upstream greyscale pixel FIFO into the kernel line-buffer controller.
- Transfers exactly one line of LINE_LENGTH pixels per downstream request.
- Tracks line position within the frame.
- After the last line of a frame, appends one pad line so the downstream kernel can emit its final output row, then pulses frame-done.

Parameters:
- LINE_LENGTH, 640, pixels per line.
- FRAME_LINES, 480, lines per frame.
- PAD_VALUE, 8'h00, greyscale value driven during the pad line.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_enable  in  1  permits new line transfers; sampled only in IDLE
- i_fifo_empty  in  1  upstream FIFO empty flag
- i_fifo_rdata  in  8  upstream FIFO read data, valid the cycle after o_fifo_rd
- o_fifo_rd  out  1  upstream FIFO read strobe
- i_req  in  1  downstream request: ready for one more line
- o_data  out  8  pixel to kernel controller
- o_valid  out  1  o_data qualifier
- o_line_cnt  out  $clog2(FRAME_LINES+1)  image lines fully delivered in the current frame
- o_busy  out  1  high in any state other than IDLE
- o_frame_done  out  1  one-cycle pulse when the pad line completes

Behaviour:
- Reset values: o_fifo_rd=0, o_valid=0, o_data=0, o_line_cnt=0, o_busy=0, o_frame_done=0.
  - Reset also clears all counters and sets state to IDLE.
  - Reset mid-line abandons the line; no partial-line recovery is attempted.
- States: IDLE, LINE, DRAIN, PAD, DONE.
- IDLE:
  - i_req && i_enable -> LINE, with issue counter cleared.
  - Otherwise stay in IDLE.
  - i_req is sampled only here; a change in i_req during LINE or PAD is ignored.
- LINE:
  - o_fifo_rd = !i_fifo_empty && (issue_cnt < LINE_LENGTH). This is combinational, so no read is ever issued on an empty FIFO.
  - issue_cnt increments on each read.
  - A FIFO underflow simply stalls the line; there is no timeout.
  - When issue_cnt reaches LINE_LENGTH -> DRAIN.
- Output timing (registered):
  - o_valid <= o_fifo_rd (1-cycle latency).
  - o_data <= i_fifo_rdata when o_valid is asserted; o_data otherwise holds its value.
  - Consequence: pixel N from the FIFO appears on o_data two cycles after its rd strobe.
- DRAIN:
  - Exactly one cycle, letting the last valid pixel retire.
  - o_line_cnt increments.
  - If the new count == FRAME_LINES -> PAD, else -> IDLE.
- PAD:
  - Drives o_valid=1 and o_data=PAD_VALUE for exactly LINE_LENGTH consecutive cycles.
  - No FIFO reads and no i_req check.
  - Then -> DONE.
- DONE:
  - One cycle: o_frame_done=1, o_line_cnt cleared to 0, then -> IDLE.
- Throughput: at most one pixel per cycle; a full line with no FIFO stalls takes LINE_LENGTH+1 cycles from LINE entry to DRAIN exit.
- Counter wrap: issue_cnt never exceeds LINE_LENGTH; o_line_cnt never exceeds FRAME_LINES.
- Simultaneous events:
  - i_fifo_empty deasserting on the same cycle as the final issue is handled normally.
  - i_req high in DONE is not consumed; it is re-sampled in the following IDLE.
- Deasserting i_enable mid-line does not abort the line. It only blocks the next line start.

Optional Feature:
- Macro: PS_LINE_FEEDER_STATS_EN.
- Defined: adds output o_stall_cnt [15:0].
  - Counts LINE-state cycles where issue_cnt < LINE_LENGTH and i_fifo_empty=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset and in DONE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Default params, FIFO preloaded with 640 pixels 0..255 repeating, pulse i_req -> 640 o_valid cycles, o_data matches FIFO order, o_line_cnt=1, state returns to IDLE; first o_valid appears 2 cycles after i_req is sampled.
2. FIFO empties at pixel 100 for 7 cycles -> o_valid gaps exactly 7 cycles; total valid count is still 640; with PS_LINE_FEEDER_STATS_EN, o_stall_cnt=7.
3. Full frame, FRAME_LINES=4, LINE_LENGTH=8 -> 32 FIFO pixels, then 8 PAD_VALUE pixels with o_fifo_rd=0, then a single-cycle o_frame_done; o_line_cnt is 4 before DONE and 0 after.
4. i_req high while i_enable=0 -> no o_fifo_rd and no state change; raising i_enable starts the line on the next cycle.
5. Assert i_rstn=0 at pixel 300 of a line -> next cycle all outputs are at their reset values; a fresh i_req delivers a full 640-pixel line from the current FIFO head.
6. i_fifo_empty held at 1 for a whole line attempt -> o_fifo_rd never asserts; o_busy stays 1 and state stays LINE.
